subtractor_serial: RTL and testbench

- Multi-cycle subtractor; the inverse operation of the team's slice-based adders.
- Computes diff = a - b over WIDTH-bit unsigned operands, one SLICE-bit chunk per clock, LSB chunk first.
- A borrow flip-flop carries between chunks; the final borrow is reported separately.
- Valid/ready handshakes on input and output so it can sit between pipelined datapath stages.

---
 rtl/subtractor_serial.sv | 86 ++++++++
 tb/tb_subtractor_serial.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor_serial.sv
// Multi-cycle unsigned subtractor: diff = a - b, one SLICE-bit chunk per clock, LSB first,
// with valid/ready handshakes on both sides and the final borrow reported as borrow_out.
module subtractor_serial #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [SLICE:0]   sub;
  logic [WIDTH-1:0] diff_ins;

  // Operands shift right and diff fills from the top, so slice i is always at
  // the operand LSBs and lands at diff[i*SLICE +: SLICE] after the last shift.
  always_comb begin
    sub      = {1'b0, a_lat[SLICE-1:0]} - {1'b0, b_lat[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
    diff_ins = (diff >> SLICE) | (WIDTH'(sub[SLICE-1:0]) << (WIDTH - SLICE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      borrow     <= 1'b0;
      cnt        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_lat    <= a;
            b_lat    <= b;
            borrow   <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          a_lat  <= a_lat >> SLICE;
          b_lat  <= b_lat >> SLICE;
          diff   <= diff_ins;
          borrow <= sub[SLICE];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NSLICE - 1)) begin
            borrow_out <= sub[SLICE];
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial: a 4-bit and an 8-bit instance checked every
// cycle against a transaction-level model, plus directed vectors with literal expectations.
module tb_subtractor_serial;

  logic clk;
  logic rst_n;

  logic       iv   [2];
  logic       ordy [2];
  logic [7:0] a_v  [2];
  logic [7:0] b_v  [2];
  logic       ir   [2];
  logic       ov   [2];
  logic       bo   [2];
  logic [7:0] df   [2];

  logic       ir0, ir1, ov0, ov1, bo0, bo1;
  logic [3:0] df0;
  logic [7:0] df1;

  int n_checks = 0;
  int n_err    = 0;

  subtractor_serial #(.WIDTH(4), .SLICE(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir0), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .diff(df0), .borrow_out(bo0)
  );

  subtractor_serial #(.WIDTH(8), .SLICE(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir1), .a(a_v[1]), .b(b_v[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .diff(df1), .borrow_out(bo1)
  );

  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign bo[0] = bo0;
  assign bo[1] = bo1;
  assign df[0] = {4'b0000, df0};
  assign df[1] = df1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: result is plain (a-b) mod 2^W, ready after NSLICE edges.
  int unsigned mw   [2] = '{4, 8};
  int          mns  [2] = '{2, 4};
  logic        m_ready  [2];
  logic        m_valid  [2];
  logic        m_borrow [2];
  int          m_diff   [2];
  int          m_a      [2];
  int          m_b      [2];
  int          m_left   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ready[k] = 1'b1; m_valid[k] = 1'b0; m_left[k] = 0;
        m_diff[k] = 0; m_borrow[k] = 1'b0;
      end else if (m_ready[k]) begin
        if (iv[k] === 1'b1) begin
          m_ready[k] = 1'b0;
          m_left[k]  = mns[k];
          m_a[k]     = int'(a_v[k]) & ((1 << mw[k]) - 1);
          m_b[k]     = int'(b_v[k]) & ((1 << mw[k]) - 1);
        end
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_valid[k]  = 1'b1;
          m_diff[k]   = (m_a[k] - m_b[k]) & ((1 << mw[k]) - 1);
          m_borrow[k] = (m_a[k] < m_b[k]);
        end
      end else if (ordy[k] === 1'b1) begin
        m_valid[k] = 1'b0;
        m_ready[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 32'(ir[k]), 32'(m_ready[k]));
      chk("out_valid", k, 32'(ov[k]), 32'(m_valid[k]));
      if (m_valid[k]) begin
        chk("diff", k, 32'(df[k]), 32'(m_diff[k]));
        chk("borrow_out", k, 32'(bo[k]), 32'(m_borrow[k]));
      end
    end
  end

  task automatic run_txn(input int k, input int av, input int bv, input int hold,
                         input int exp_d, input int exp_b, input int exp_lat);
    int lat;
    @(negedge clk);
    a_v[k] = 8'(av); b_v[k] = 8'(bv); iv[k] = 1'b1; ordy[k] = (hold == 0);
    @(posedge clk); #1;
    chk("accepted", k, 32'(ir[k]), 32'(0));
    @(negedge clk);
    iv[k] = 1'b0; a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ov[k] !== 1'b1 && lat < 20);
    chk("latency", k, 32'(lat), 32'(exp_lat));
    chk("lit_diff", k, 32'(df[k]), 32'(exp_d));
    chk("lit_borrow", k, 32'(bo[k]), 32'(exp_b));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      a_v[k] = 8'($urandom); b_v[k] = 8'($urandom); iv[k] = 1'($urandom);
      @(posedge clk); #1;
      chk("held_valid", k, 32'(ov[k]), 32'(1));
      chk("held_diff", k, 32'(df[k]), 32'(exp_d));
      chk("held_busy", k, 32'(ir[k]), 32'(0));
    end
    @(negedge clk);
    iv[k] = 1'b0; ordy[k] = 1'b1;
    @(posedge clk); #1;
    chk("released", k, 32'(ov[k]), 32'(0));
    chk("ready_back", k, 32'(ir[k]), 32'(1));
  endtask

  initial begin
    int av, bv;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, 32'(ir[k]), 32'(1));
      chk("rst_out_valid", k, 32'(ov[k]), 32'(0));
      chk("rst_diff", k, 32'(df[k]), 32'(0));
      chk("rst_borrow", k, 32'(bo[k]), 32'(0));
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_txn(0,  9,  3, 0, 'h6, 0, 2);
    run_txn(0,  3,  9, 0, 'hA, 1, 2);
    run_txn(0,  0,  1, 0, 'hF, 1, 2);
    run_txn(0, 15, 15, 0, 'h0, 0, 2);
    run_txn(0,  0,  0, 0, 'h0, 0, 2);
    run_txn(0, 12,  5, 5, 'h7, 0, 2);
    run_txn(0,  0, 15, 1, 'h1, 1, 2);

    // Reset in the middle of a BUSY transaction.
    @(negedge clk);
    a_v[0] = 8'd9; b_v[0] = 8'd3; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 0, 32'(ir[0]), 32'(1));
    chk("midrst_out_valid", 0, 32'(ov[0]), 32'(0));
    chk("midrst_diff", 0, 32'(df[0]), 32'(0));
    chk("midrst_borrow", 0, 32'(bo[0]), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(0, 6, 2, 0, 'h4, 0, 2);

    run_txn(1, 'h80, 'h01, 0, 'h7F, 0, 4);
    run_txn(1, 'h00, 'hFF, 1, 'h01, 1, 4);

    for (int i = 0; i < 1000; i++) begin
      av = int'($urandom_range(0, 255));
      bv = int'($urandom_range(0, 255));
      run_txn(1, av, bv, int'($urandom_range(0, 2)), (av - bv) & 'hFF, int'(av < bv), 4);
    end
    for (int i = 0; i < 100; i++) begin
      av = int'($urandom_range(0, 15));
      bv = int'($urandom_range(0, 15));
      run_txn(0, av, bv, int'($urandom_range(0, 1)), (av - bv) & 'hF, int'(av < bv), 2);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
